// File: rtl/ufd_fifo_pkg.sv
// Shared constants and helpers for the sync_fifo_dp FIFO: default geometry,
// error-flag bit positions and the level-width helper.
package ufd_fifo_pkg;

    localparam int UFD_ASIZE = 3;
    localparam int UFD_DSIZE = 8;

    // Bit positions inside the sticky error vector
    localparam int ERR_OVF = 0;
    localparam int ERR_UDF = 1;
    localparam int ERR_W   = 2;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Dual-port storage for sync_fifo_dp: synchronous write, asynchronous read.
// The array carries no reset so it maps onto distributed RAM.
module fifo_ram #(
    parameter int ASIZE = 3,
    parameter int DSIZE = 8
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [ASIZE-1:0] i_waddr,
    input  logic [DSIZE-1:0] i_wdata,
    input  logic [ASIZE-1:0] i_raddr,
    output logic [DSIZE-1:0] o_rdata
);

    logic [DSIZE-1:0] mem [0:(1<<ASIZE)-1];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/sync_fifo_dp.sv
// Single-clock FIFO with level counter, almost-full/empty and sticky error flags.
// Define FIFO_FWFT_EN for first-word-fall-through output; default is registered output.
module sync_fifo_dp
    import ufd_fifo_pkg::*;
#(
    parameter int ASIZE     = UFD_ASIZE,
    parameter int DSIZE     = UFD_DSIZE,
    parameter int AFULL_TH  = 6,
    parameter int AEMPTY_TH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_we,
    input  logic [DSIZE-1:0] i_data,
    input  logic             i_re,
    output logic [DSIZE-1:0] o_data,
    output logic             o_rvalid,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_afull,
    output logic             o_aempty,
    output logic [ASIZE:0]   o_level,
    output logic             o_ovf,
    output logic             o_udf,
    input  logic             i_clr_err
);

    localparam int DEPTH = 1 << ASIZE;
    localparam int LVL_W = clog2(DEPTH + 1);

    localparam logic [LVL_W-1:0] DEPTH_LV  = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] AFULL_LV  = LVL_W'(AFULL_TH);
    localparam logic [LVL_W-1:0] AEMPTY_LV = LVL_W'(AEMPTY_TH);

    logic [ASIZE-1:0]  wptr_reg, wptr_next;
    logic [ASIZE-1:0]  rptr_reg, rptr_next;
    logic [LVL_W-1:0]  level_reg, level_next;
    logic [ERR_W-1:0]  err_reg, err_next;
    logic              wr_ok, rd_ok;
    logic              wr_fire, rd_fire;
    logic [DSIZE-1:0]  ram_rdata;

    // A pop frees a slot in the same cycle, so a full FIFO still takes a write alongside it
    assign rd_ok   = i_re & ~o_empty;
    assign wr_ok   = i_we & (~o_full | rd_ok);
    assign wr_fire = wr_ok & ~i_flush;
    assign rd_fire = rd_ok & ~i_flush;

    fifo_ram #(
        .ASIZE (ASIZE),
        .DSIZE (DSIZE)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (wr_fire),
        .i_waddr (wptr_reg),
        .i_wdata (i_data),
        .i_raddr (rptr_reg),
        .o_rdata (ram_rdata)
    );

    always_comb begin
        wptr_next  = wptr_reg;
        rptr_next  = rptr_reg;
        level_next = level_reg;
        if (i_flush) begin
            wptr_next  = '0;
            rptr_next  = '0;
            level_next = '0;
        end else begin
            if (wr_fire) wptr_next = wptr_reg + ASIZE'(1);
            if (rd_fire) rptr_next = rptr_reg + ASIZE'(1);
            case ({wr_fire, rd_fire})
                2'b10:   level_next = level_reg + LVL_W'(1);
                2'b01:   level_next = level_reg - LVL_W'(1);
                default: level_next = level_reg;
            endcase
        end
    end

    // Setting an error outranks clearing it in the same cycle
    always_comb begin
        err_next = err_reg;
        if (i_clr_err) err_next = '0;
        if (i_we & ~wr_ok) err_next[ERR_OVF] = 1'b1;
        if (i_re & ~rd_ok) err_next[ERR_UDF] = 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            level_reg <= '0;
            err_reg   <= '0;
        end else begin
            wptr_reg  <= wptr_next;
            rptr_reg  <= rptr_next;
            level_reg <= level_next;
            err_reg   <= err_next;
        end
    end

    assign o_level  = level_reg;
    assign o_full   = (level_reg == DEPTH_LV);
    assign o_empty  = (level_reg == '0);
    assign o_afull  = (level_reg >= AFULL_LV);
    assign o_aempty = (level_reg <= AEMPTY_LV);
    assign o_ovf    = err_reg[ERR_OVF];
    assign o_udf    = err_reg[ERR_UDF];

`ifdef FIFO_FWFT_EN
    // Head word is shown directly; masked while empty so stale RAM never leaks out
    assign o_data   = o_empty ? '0 : ram_rdata;
    assign o_rvalid = ~o_empty;
`else
    logic [DSIZE-1:0] data_reg;
    logic             rvalid_reg;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data_reg   <= '0;
            rvalid_reg <= 1'b0;
        end else begin
            rvalid_reg <= rd_fire;
            if (rd_fire) data_reg <= ram_rdata;
        end
    end

    assign o_data   = data_reg;
    assign o_rvalid = rvalid_reg;
`endif

endmodule
